// File: rtl/prio_sel_pkg.sv
// rtl/prio_sel_pkg.sv - shared sizing helpers and sel-field layout for the priority data-select pipe
package prio_sel_pkg;

    // Bits needed to hold a lane index in 0..n, where n is the default lane
    function automatic int clog2p1(input int n);
        return $clog2(n + 1);
    endfunction

    // out_sel = {bypass_taken, lane_idx}; the bypass flag sits just above the index
    function automatic int byp_bit(input int n);
        return clog2p1(n);
    endfunction

    function automatic int default_idx(input int n);
        return n;
    endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// rtl/prio_enc_lsb.sv - lowest-set-bit priority encoder, returns N when no request is set
module prio_enc_lsb
    import prio_sel_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2p1(N)
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx = IW'(default_idx(N));
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) idx = IW'(k);
        end
    end

endmodule

// File: rtl/prio_sel_dsr_pipe.sv
// rtl/prio_sel_dsr_pipe.sv - two-stage priority lane select with late-vetoed bypass and bypass counter
module prio_sel_dsr_pipe
    import prio_sel_pkg::*;
#(
    parameter int DW    = 8,
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [(N+1)*DW-1:0]    in_data,
    input  logic [N-1:0]           in_cond,
    input  logic [DW-1:0]          byp_data,
    input  logic                   byp_req,
    input  logic                   late_ctrl,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic [$clog2(N+1):0]   out_sel,
    output logic [CNT_W-1:0]       byp_cnt,
    input  logic                   cnt_clr
);

    localparam int IW = clog2p1(N);

    logic [DW-1:0] lanes [N+1];
    logic [IW-1:0] enc_idx;

    logic          s1_valid;
    logic [DW-1:0] z1_q;
    logic [DW-1:0] z2_q;
    logic [IW-1:0] idx_q;
    logic          byp_q;

    logic s2_take;
    logic accept;
    logic s2_load;
    logic take_byp;
    logic deliver;

    for (genvar k = 0; k <= N; k++) begin : g_lane
        assign lanes[k] = in_data[k*DW +: DW];
    end

    prio_enc_lsb #(.N(N), .IW(IW)) u_enc (
        .req (in_cond),
        .idx (enc_idx)
    );

    assign s2_take  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_take;
    assign accept   = in_valid && in_ready;
    assign s2_load  = s1_valid && s2_take;
    assign deliver  = out_valid && out_ready;

    // Only the late veto remains in front of the output register; the priority pick is already in z1_q
    assign take_byp = byp_q && !late_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            z1_q     <= '0;
            z2_q     <= '0;
            idx_q    <= '0;
            byp_q    <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                z1_q     <= lanes[enc_idx];
                z2_q     <= byp_data;
                idx_q    <= enc_idx;
                byp_q    <= byp_req;
            end else if (s2_take) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else begin
            if (s2_load) begin
                out_valid <= 1'b1;
                out_data  <= take_byp ? z2_q : z1_q;
                out_sel   <= {take_byp, idx_q};
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_cnt <= '0;
        end else if (cnt_clr) begin
            byp_cnt <= '0;
        end else if (deliver && out_sel[byp_bit(N)] && (byp_cnt != '1)) begin
            byp_cnt <= byp_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_prio_sel_dsr_pipe.sv
// tb/tb_prio_sel_dsr_pipe.sv - scoreboard bench for prio_sel_dsr_pipe with directed stimulus
module tb_prio_sel_dsr_pipe;

    localparam int DW    = 8;
    localparam int N     = 4;
    localparam int CNT_W = 2;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [(N+1)*DW-1:0]  in_data;
    logic [N-1:0]         in_cond;
    logic [DW-1:0]        byp_data;
    logic                 byp_req;
    logic                 late_ctrl;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic [3:0]           out_sel;
    logic [CNT_W-1:0]     byp_cnt;
    logic                 cnt_clr;

    prio_sel_dsr_pipe #(.DW(DW), .N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cond   (in_cond),
        .byp_data  (byp_data),
        .byp_req   (byp_req),
        .late_ctrl (late_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .byp_cnt   (byp_cnt),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [3:0] s;
        int         c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_cnt = 0;
    int   delivered = 0;
    bit   check_lat = 1'b0;

    localparam logic [(N+1)*DW-1:0] LANES = 40'h54_43_32_21_10;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on accept, pop and compare on delivery, track the counter
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_cnt = 0;
        end else begin
            bit   dlv_byp;
            exp_t e;
            int   idx;
            bit   tb_byp;
            dlv_byp = 1'b0;
            chk("byp_cnt", 32'(byp_cnt), 32'(exp_cnt));
            if (out_valid && out_ready) begin
                delivered++;
                if (q.size() == 0) begin
                    chk("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_sel", 32'(out_sel), 32'(e.s));
                    if (check_lat) chk("latency", 32'(cyc - e.c), 32'd2);
                    dlv_byp = e.s[3];
                end
            end
            if (cnt_clr) exp_cnt = 0;
            else if (dlv_byp && exp_cnt != SAT) exp_cnt++;
            if (in_valid && in_ready) begin
                idx = N;
                for (int k = N - 1; k >= 0; k--) if (in_cond[k]) idx = k;
                tb_byp = byp_req && !late_ctrl;
                e.d = tb_byp ? byp_data : in_data[idx*DW +: DW];
                e.s = {tb_byp, 3'(idx)};
                e.c = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] c, input logic b, input bit rnd);
        int n;
        in_valid = 1'b1;
        in_cond  = c;
        byp_req  = b;
        in_data  = rnd ? {$urandom, $urandom} : LANES;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int held;
        int d0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = LANES; in_cond = '0;
        byp_data = 8'hAA; byp_req = 1'b0; late_ctrl = 1'b0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_byp_cnt", 32'(byp_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Priority select
        check_lat = 1'b1;
        send(4'b0110, 1'b0, 1'b0);
        drain();
        chk("prio_0110_data", 32'(out_data), 32'h21);
        send(4'b0000, 1'b0, 1'b0);
        drain();
        chk("prio_default_data", 32'(out_data), 32'h54);
        chk("prio_default_sel", 32'(out_sel), 32'h4);

        // Bypass with and without late veto
        send(4'b0001, 1'b1, 1'b0);
        drain();
        chk("byp_data", 32'(out_data), 32'hAA);
        chk("byp_sel", 32'(out_sel), 32'h8);
        chk("byp_cnt_1", 32'(byp_cnt), 32'd1);
        late_ctrl = 1'b1;
        send(4'b0001, 1'b1, 1'b0);
        drain();
        chk("veto_data", 32'(out_data), 32'h10);
        chk("veto_sel", 32'(out_sel), 32'h0);
        chk("veto_cnt", 32'(byp_cnt), 32'd1);
        late_ctrl = 1'b0;

        // Back-pressure
        check_lat = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_cond = 4'($urandom); byp_req = 1'($urandom); in_data = {$urandom, $urandom};
        step();
        in_cond = 4'($urandom); byp_req = 1'($urandom); in_data = {$urandom, $urandom};
        step();
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        held = 32'(out_data);
        step();
        chk("bp_hold_1", 32'(out_data), held);
        chk("bp_in_ready_still_low", 32'(in_ready), 32'd0);
        step();
        chk("bp_hold_2", 32'(out_data), held);
        in_valid = 1'b0;
        out_ready = 1'b1;
        send(4'($urandom), 1'($urandom), 1'b1);
        send(4'($urandom), 1'($urandom), 1'b1);
        drain();

        // Full throughput
        check_lat = 1'b1;
        d0 = delivered;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_cond = 4'($urandom); byp_req = 1'($urandom);
            in_data = {$urandom, $urandom}; byp_data = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        drain();
        chk("tput_count", 32'(delivered - d0), 32'd8);
        byp_data = 8'hAA;

        // Counter saturation and clear priority
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_cond = 4'($urandom); byp_req = 1'b1; in_data = {$urandom, $urandom};
            step();
        end
        in_valid = 1'b0;
        drain();
        chk("cnt_saturate", 32'(byp_cnt), 32'(SAT));
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("cnt_clear", 32'(byp_cnt), 32'd0);
        send(4'b0010, 1'b1, 1'b1);
        drain();
        chk("cnt_after_one", 32'(byp_cnt), 32'd1);
        check_lat = 1'b0;
        out_ready = 1'b0;
        send(4'b0010, 1'b1, 1'b1);
        step(); step();
        chk("cnt_stalled_valid", 32'(out_valid), 32'd1);
        cnt_clr = 1'b1; out_ready = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("cnt_clr_wins", 32'(byp_cnt), 32'd0);
        drain();

        // Async reset mid-stream
        out_ready = 1'b0;
        send(4'b0001, 1'b1, 1'b1);
        send(4'b0100, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_byp_cnt", 32'(byp_cnt), 32'd0);
        q.delete();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 10; i++) step();
        chk("arst_no_stale", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prio_sel_dsr_pipe.md
Name: prio_sel_dsr_pipe

Overview:
- Parametrised, pipelined successor to the single-bit priority data-select block.
- Selects one of N prioritised data lanes, or a default lane, for each accepted beat. Optionally overrides the result with a bypass word. The override is gated by a late-arriving control.
- Data-select restructuring is done in hardware: the early priority decision is registered in stage 1, so the late control only drives one 2:1 mux in front of the output register.
- Sits between the control decode and the datapath result bus, with valid/ready on both sides.

Parameters:
- DW, 8: data width of every lane and of the output.
- N, 4: number of prioritised lanes; lane N is the default lane. N >= 2.
- CNT_W, 16: width of the bypass-event counter (saturating).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage 1 can accept.
- in_data  in  (N+1)*DW  lane k occupies bits [k*DW +: DW]; lane N is the default lane.
- in_cond  in  N  early priority conditions; bit 0 has highest priority.
- byp_data  in  DW  bypass word (Z2).
- byp_req  in  1  early bypass qualifier for this beat.
- late_ctrl  in  1  late-arriving veto for the beat held in stage 1.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DW  selected word.
- out_sel  out  $clog2(N+1)+1  lane index; MSB=1 means bypass taken.
- byp_cnt  out  CNT_W  number of beats delivered with bypass taken.
- cnt_clr  in  1  synchronous clear of byp_cnt.

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, out_valid=0, out_data=0, out_sel=0, byp_cnt=0. in_ready=1 once reset is released.
- Handshakes:
  - s2_take = !out_valid | out_ready.
  - in_ready = !s1_valid | s2_take.
  - A beat is accepted when in_valid & in_ready.
  - A beat is delivered when out_valid & out_ready.
- Stage 1 capture (on accept):
  - idx = lowest k with in_cond[k]=1; if in_cond==0, idx=N.
  - z1_q = lane idx; idx_q = idx; z2_q = byp_data; byp_q = byp_req.
  - Any set in_cond bit other than the winner is ignored.
- s1_valid: set on accept. Cleared when s2_take with no new accept. Stays 1 on simultaneous take and accept.
- late_ctrl:
  - Belongs to the beat in stage 1.
  - Sampled only in the cycle s1_valid & s2_take.
  - The source holds it stable while stage 1 is stalled. It is don't-care when s1_valid=0.
- Stage 2 load (s1_valid & s2_take):
  - take_byp = byp_q & ~late_ctrl.
  - out_data = take_byp ? z2_q : z1_q.
  - out_sel = {take_byp, idx_q}.
  - out_valid=1.
- When out_ready & !s1_valid, out_valid clears; out_data and out_sel keep their last value.
- Latency: 2 cycles from accept to out_valid with no stalls. Throughput is 1 beat/cycle.
- Stall: when out_valid & !out_ready, out_data and out_sel hold stable. Stage 1 holds its contents, and in_ready = !s1_valid.
- Counter:
  - byp_cnt increments on each delivered beat with out_sel MSB=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over a same-cycle increment (result 0).
- Reset mid-operation: all in-flight beats are dropped with no partial output, and the counter clears.
- Combinational paths: none from inputs to out_*. in_ready depends on out_ready combinationally.

Decomposition:
- Shared package prio_sel_pkg:
  - idx width function clog2p1(N).
  - Sel-field layout constants: BYP_BIT position, DEFAULT_IDX=N.
- One natural sub-module: prio_enc_lsb, parametrised by N. It outputs the lowest set index, or N when the input is zero. It is reused by the stage-1 capture.

Test Plan (DW=8, N=4; lanes 0..4 = 10,21,32,43,54 hex; byp_data=AA):
- Priority: in_cond=0110, byp_req=0, out_ready=1 -> 2 cycles later out_data=21, out_sel=0_001. in_cond=0000 -> out_data=54, out_sel=0_100.
- Bypass with late veto: in_cond=0001, byp_req=1. With late_ctrl=0 at the stage-1 transfer -> out_data=AA, out_sel=1_000, byp_cnt=1. Repeat with late_ctrl=1 -> out_data=10, byp_cnt unchanged.
- Back-pressure: stream 4 beats with out_ready=0 for 3 cycles -> in_ready drops after 2 beats accepted, out_data holds, no beat lost or duplicated. Order is preserved once out_ready=1.
- Full throughput: 8 consecutive beats with out_ready=1 -> 8 outputs on consecutive cycles, each 2 cycles after its accept.
- Counter: CNT_W=2, 5 bypass beats -> byp_cnt saturates at 3. cnt_clr asserted during an increment -> byp_cnt=0.
- Async reset: assert rst_n=0 mid-stream, asynchronous to clk -> out_valid=0, out_data=0, byp_cnt=0 immediately. No stale beat emerges after release.
